// File: rtl/prpg_pkg.sv
// prpg_pkg: shared types, widths and LFSR step rule for the PRPG generator and checker
package prpg_pkg;
  localparam int TAP_W = 7;
  localparam int PAT_W = 8;
  localparam logic [TAP_W-1:0] DEFAULT_TAP = 7'b0100101;
  typedef enum logic [1:0] {IDLE = 2'd0, SYNC = 2'd1, LOCKED = 2'd2} state_t;
  function automatic logic [0:PAT_W-1] lfsr_next(input logic [0:PAT_W-1] p, input logic [TAP_W-1:0] tap);
    logic [0:PAT_W-1] q;
    q[0] = p[PAT_W-1];
    for (int k = 1; k < PAT_W; k++) q[k] = p[k-1] ^ (tap[PAT_W-1-k] & p[PAT_W-1]);
    return q;
  endfunction
endpackage

// File: rtl/prpg_checker_popcount8.sv
// popcount8: combinational population count of an 8-bit word (d -> n, 0..8)
module popcount8 (
  input  logic [7:0] d,
  output logic [3:0] n
);
  always_comb begin
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, d[i]};
  end
endmodule

// File: rtl/prpg_checker.sv
// prpg_checker: self-synchronising PRPG pattern checker; ports clk/rst_n, cfg_we/cfg_tap, in_valid/in_data, clear -> locked, state, err_flag, bit_err, word/err/bit-error counters
module prpg_checker
  import prpg_pkg::*;
#(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [6:0]       cfg_tap,
  input  logic             in_valid,
  input  logic [0:7]       in_data,
  input  logic             clear,
  output logic             locked,
  output logic [1:0]       state,
  output logic             err_flag,
  output logic [3:0]       bit_err,
  output logic [CNT_W-1:0] word_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] bit_err_cnt
);
  localparam int MR_W = $clog2(LOCK_CNT + 1);
  localparam int MS_W = $clog2(LOSS_CNT + 1);
  state_t st, st_n;
  logic [TAP_W-1:0] tap;
  logic [0:7] expected, exp_n;
  logic [MR_W-1:0] match_run, mr_n;
  logic [MS_W-1:0] miss_run, ms_n;
  logic [3:0] pc;
  logic hit, cmp, cnt;
  function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] a, input logic [3:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(b);
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction
  popcount8 u_pc (.d(in_data ^ expected), .n(pc));
  assign hit = in_data == expected;
  assign cmp = in_valid & ~cfg_we & (st != IDLE);
  assign cnt = cmp & (st == LOCKED);
  assign locked = st == LOCKED;
  assign state = st;
  always_comb begin
    st_n = st;
    exp_n = expected;
    mr_n = match_run;
    ms_n = miss_run;
    if (cfg_we) st_n = IDLE;
    else if (in_valid)
      case (st)
        IDLE: if (|in_data) begin
          st_n = SYNC;
          exp_n = lfsr_next(in_data, tap);
          mr_n = '0;
        end
        SYNC: if (hit) begin
          exp_n = lfsr_next(in_data, tap);
          mr_n = match_run + MR_W'(1);
          if (mr_n == MR_W'(LOCK_CNT)) begin
            st_n = LOCKED;
            ms_n = '0;
          end
        end else if (|in_data) begin
          exp_n = lfsr_next(in_data, tap);
          mr_n = '0;
        end else st_n = IDLE;
        LOCKED: begin
          exp_n = lfsr_next(expected, tap);
          ms_n = hit ? '0 : miss_run + MS_W'(1);
          if (ms_n == MS_W'(LOSS_CNT)) begin
            st_n = SYNC;
            exp_n = lfsr_next(in_data, tap);
            mr_n = '0;
          end
        end
        default: st_n = IDLE;
      endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= IDLE;
      tap <= DEFAULT_TAP;
      expected <= '0;
      match_run <= '0;
      miss_run <= '0;
      err_flag <= 1'b0;
      bit_err <= '0;
      word_cnt <= '0;
      err_cnt <= '0;
      bit_err_cnt <= '0;
    end else begin
      st <= st_n;
      tap <= cfg_we ? cfg_tap : tap;
      expected <= exp_n;
      match_run <= mr_n;
      miss_run <= ms_n;
      err_flag <= cnt & ~hit;
      bit_err <= cmp ? pc : bit_err;
      if (clear) begin
        word_cnt <= '0;
        err_cnt <= '0;
        bit_err_cnt <= '0;
      end else if (cnt) begin
        word_cnt <= sat(word_cnt, 4'd1);
        err_cnt <= hit ? err_cnt : sat(err_cnt, 4'd1);
        bit_err_cnt <= sat(bit_err_cnt, pc);
      end
    end
endmodule

// File: doc/prpg_checker.md
# prpg_checker

Receive-side companion to the 8-bit internal-XOR PRPG. It accepts the generator's pattern stream, self-synchronises by seeding a local copy of the LFSR from received words, and then free-runs that copy to predict each next word. It reports lock status, per-word Hamming distance and saturating word, error and bit-error counters. It sits at the far end of the pattern path as the PRPG's verifier.

## Interface
Parameters:
- LOCK_CNT, 4: consecutive matches in SYNC required to enter LOCKED.
- LOSS_CNT, 3: consecutive mismatches in LOCKED that drop back to SYNC.
- CNT_W, 16: width of every statistics counter.

Ports (clock and reset first):
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- cfg_we  in  1  loads cfg_tap; FSM forced to IDLE.
- cfg_tap  in  7  tap vector; tap[6] feeds bit 1 and tap[0] feeds bit 7.
- in_valid  in  1  in_data is valid this cycle.
- in_data  in  [0:7]  received pattern.
- clear  in  1  synchronous zero of all counters.
- locked  out  1  high while state is LOCKED.
- state  out  2  IDLE=0, SYNC=1, LOCKED=2.
- err_flag  out  1  one-cycle pulse on a mismatch in LOCKED.
- bit_err  out  4  Hamming distance of the last compared word (0..8).
- word_cnt, err_cnt, bit_err_cnt  out  CNT_W each  words compared, words in error and bits in error while LOCKED; all saturate at all-ones.

## Operation
- LFSR step nx(P): nx[0]=P[7]; for k=1..7, nx[k]=P[k-1] ^ (cfg_tap[7-k] & P[7]). The result is held in a register `expected`.
- IDLE: on in_valid with in_data≠0, set expected=nx(in_data), clear match_run and go to SYNC. A zero word is ignored because it is the LFSR lockup state.
- SYNC, on in_valid:
  - Match (in_data==expected): expected=nx(in_data) and match_run+1. When match_run reaches LOCK_CNT, go to LOCKED and clear miss_run.
  - Mismatch with in_data≠0: reseed with expected=nx(in_data) and set match_run=0.
  - Mismatch with in_data==0: go to IDLE.
- LOCKED, on in_valid:
  - Compare in_data with expected. bit_err=popcount(in_data^expected).
  - word_cnt+1 on every compare. bit_err_cnt+=bit_err.
  - On mismatch: err_cnt+1, err_flag pulses, miss_run+1.
  - On match: miss_run=0.
  - expected=nx(expected) on every compare (flywheel; it never reseeds from data while LOCKED).
  - When miss_run reaches LOSS_CNT, go to SYNC with expected=nx(in_data) and match_run=0.
- Outside LOCKED, bit_err still updates on each compare, but counters and err_flag do not change.
- Counters saturate. An addition that overflows clamps to all-ones.

## Timing
- All outputs are registered, with 1-cycle latency. A word sampled at edge k is reflected in state, counters, bit_err and err_flag after edge k.
- err_flag is high for exactly the cycle after a mismatched LOCKED word. It is low otherwise, including during back-to-back valid words that match.
- in_valid low: no state change. Idle gaps do not advance expected.
- Reset values: state=IDLE, locked=0, err_flag=0, bit_err=0, all counters=0, expected=0, match_run=miss_run=0, tap=7'b0100101.
- Priority within one edge:
  - cfg_we beats in_valid. The word is dropped, the tap loads and the state goes to IDLE. Counters are kept.
  - clear beats counting. Counters become 0 and that cycle's compare is not counted, but the FSM and bit_err still advance.
- rst_n asserted mid-stream: everything returns to reset values immediately. Resynchronisation needs 1+LOCK_CNT valid words.

## Structure
- Package prpg_pkg holds:
  - the state enum;
  - TAP_W=7 and PAT_W=8;
  - DEFAULT_TAP=7'b0100101;
  - function lfsr_next(pattern, tap), shared with the generator so both ends use the same step rule.
- One sub-module, popcount8: combinational 8-bit population count giving a 4-bit result, used for bit_err.

## Test plan
- Sync to lock: tap 0100101, send 11111111, 11011010, 01101101, 10010011, then the continuing sequence. Expect state=SYNC after word 1 and LOCKED after word 5; word_cnt counts only words from the 6th onward; err_cnt=0.
- Single-bit error while locked: flip P[3] of one word. Expect bit_err=1, err_flag for one cycle, err_cnt=1, bit_err_cnt=1, still LOCKED. The next correct word matches thanks to the flywheel.
- Loss of lock: send 3 consecutive all-ones-inverted words while LOCKED. Expect err_cnt=3, bit_err_cnt equal to the summed Hamming distances, and state=SYNC after the third word.
- Zero word: send 00000000 in IDLE and expect no state change. Send 00000000 in SYNC and expect IDLE.
- Saturation and clear: CNT_W=4, send 20 locked erroneous words with LOSS_CNT=32. Expect err_cnt to stop at 15. Then assert clear together with a valid word and expect all counters at 0.
- Mid-stream events:
  - cfg_we while LOCKED gives IDLE with counters unchanged.
  - rst_n low for a partial cycle while LOCKED gives immediate reset values.
